// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_ctrl_pkg;

    // Machine interrupt cause codes (mcause[3:0] when mcause[31] is set).
    localparam logic [3:0] IRQ_MACH_EXTERN = 4'd11;
    localparam logic [3:0] IRQ_MACH_SOFT   = 4'd3;
    localparam logic [3:0] IRQ_MACH_TIMER  = 4'd7;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        REDIRECT
    } trap_state_type;

    // Values handed to the CSR file on a trap.
    typedef struct packed {
        logic        take;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] tval;
    } trap_ctrl_out_type;

    // Vectored-mode target: base + 4*code, the 30-bit add wraps.
    function automatic logic [31:0] vec_target(input logic [31:0] tvec, input logic [3:0] code);
        logic [29:0] base;
        base = tvec[31:2] + {26'b0, code};
        return {base, 2'b00};
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Commit/CSR/fetch signal bundle for the trap sequencer.
interface trap_ctrl_if;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_epc;
    logic [31:0] exc_tval;
    logic        mret_req;
    logic        retire_valid;
    logic [31:0] retire_npc;
    logic        mstatus_mie;
    logic [2:0]  mie_en;
    logic [2:0]  mip_pend;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        trap_take;
    logic [31:0] trap_cause;
    logic [31:0] trap_epc;
    logic [31:0] trap_tval;
    logic        mret_take;
    logic        flush;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    // Pipeline/CSR/fetch side.
    modport master (
        output exc_valid, exc_cause, exc_epc, exc_tval, mret_req, retire_valid, retire_npc,
               mstatus_mie, mie_en, mip_pend, mtvec, mepc, redirect_ready,
        input  trap_take, trap_cause, trap_epc, trap_tval, mret_take, flush, stall,
               redirect_valid, redirect_pc
    );

    // Trap sequencer side.
    modport slave (
        input  exc_valid, exc_cause, exc_epc, exc_tval, mret_req, retire_valid, retire_npc,
               mstatus_mie, mie_en, mip_pend, mtvec, mepc, redirect_ready,
        output trap_take, trap_cause, trap_epc, trap_tval, mret_take, flush, stall,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/trap_ctrl_irq_prio.sv
// Fixed-priority encoder for eligible machine interrupts: MEI > MSI > MTI.
module trap_ctrl_irq_prio
    import trap_ctrl_pkg::*;
(
    input  logic [2:0] eligible_i, // {mei, msi, mti}
    output logic       valid_o,
    output logic [3:0] code_o
);

    // Pick the highest-priority eligible source.
    always_comb begin
        valid_o = 1'b1;
        code_o  = IRQ_MACH_EXTERN;
        if (eligible_i[2]) begin
            code_o = IRQ_MACH_EXTERN;
        end else if (eligible_i[1]) begin
            code_o = IRQ_MACH_SOFT;
        end else if (eligible_i[0]) begin
            code_o = IRQ_MACH_TIMER;
        end else begin
            valid_o = 1'b0;
            code_o  = 4'd0;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: arbitrates exceptions, mret and interrupts, pulses the CSR
// commit, drains the pipeline and then holds a redirect until fetch accepts it.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter bit          VECTORED_EN  = 1'b1
) (
    input logic        clk,
    input logic        rst,
    trap_ctrl_if.slave bus
);

    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    trap_state_type    state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [31:0]       pc_q, pc_d;
    trap_ctrl_out_type trap_out;
    logic              mret_take;
    logic              go;
    logic [2:0]        irq_eligible;
    logic              irq_valid;
    logic [3:0]        irq_code;
    logic              unused_mepc_lsb;

    // mepc[0] is always cleared on return.
    assign unused_mepc_lsb = bus.mepc[0];

    assign irq_eligible = {3{bus.mstatus_mie & bus.retire_valid}} & bus.mie_en & bus.mip_pend;

    trap_ctrl_irq_prio u_irq_prio (
        .eligible_i (irq_eligible),
        .valid_o    (irq_valid),
        .code_o     (irq_code)
    );

    // Request arbitration in IDLE and sequencing through FLUSH/REDIRECT.
    always_comb begin
        trap_out  = '0;
        mret_take = 1'b0;
        go        = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_d      = pc_q;
        unique case (state_q)
            IDLE: begin
                // Takes are gated by reset so the CSR file never commits mid-reset.
                if (!rst) begin
                    if (bus.exc_valid) begin
                        go             = 1'b1;
                        trap_out.take  = 1'b1;
                        trap_out.cause = {28'b0, bus.exc_cause};
                        trap_out.epc   = bus.exc_epc;
                        trap_out.tval  = bus.exc_tval;
                        pc_d           = {bus.mtvec[31:2], 2'b00};
                    end else if (bus.mret_req) begin
                        go        = 1'b1;
                        mret_take = 1'b1;
                        pc_d      = {bus.mepc[31:1], 1'b0};
                    end else if (irq_valid) begin
                        go             = 1'b1;
                        trap_out.take  = 1'b1;
                        trap_out.cause = {1'b1, 27'b0, irq_code};
                        trap_out.epc   = bus.retire_npc;
                        trap_out.tval  = 32'b0;
                        if (VECTORED_EN && bus.mtvec[1:0] == 2'b01) begin
                            pc_d = vec_target(bus.mtvec, irq_code);
                        end else begin
                            pc_d = {bus.mtvec[31:2], 2'b00};
                        end
                    end
                end
                if (go) begin
                    state_d = FLUSH;
                    cnt_d   = 4'd0;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == FLUSH_LAST) begin
                    state_d = REDIRECT;
                end
            end
            REDIRECT: begin
                if (bus.redirect_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, drain counter and redirect target registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            pc_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
        end
    end

    assign bus.trap_take      = trap_out.take;
    assign bus.trap_cause     = trap_out.cause;
    assign bus.trap_epc       = trap_out.epc;
    assign bus.trap_tval      = trap_out.tval;
    assign bus.mret_take      = mret_take;
    assign bus.flush          = (state_q == FLUSH);
    assign bus.stall          = (state_q != IDLE);
    assign bus.redirect_valid = (state_q == REDIRECT);
    assign bus.redirect_pc    = pc_q;

    // An exception while the sequencer is busy means the pipeline failed to stall.
    a_no_exc_when_busy: assert property (@(posedge clk) disable iff (rst)
        !(bus.exc_valid && state_q != IDLE));

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl (FLUSH_CYCLES=2, VECTORED_EN=1).
module tb_trap_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    trap_ctrl_if bus ();

    trap_ctrl #(
        .FLUSH_CYCLES (2),
        .VECTORED_EN  (1'b1)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_in();
        bus.exc_valid      = 1'b0;
        bus.exc_cause      = 4'd0;
        bus.exc_epc        = 32'd0;
        bus.exc_tval       = 32'd0;
        bus.mret_req       = 1'b0;
        bus.retire_valid   = 1'b0;
        bus.retire_npc     = 32'd0;
        bus.mstatus_mie    = 1'b0;
        bus.mie_en         = 3'b000;
        bus.mip_pend       = 3'b000;
        bus.mtvec          = 32'h8000_0001;
        bus.mepc           = 32'h0000_0300;
        bus.redirect_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_in();
        @(negedge clk);
        @(negedge clk);
        bus.exc_valid = 1'b1;
        bus.exc_cause = 4'd5;
        #1;
        checks++; if (bus.trap_take !== 1'b0) begin errors++; $display("FAIL rst_take got %b want 0", bus.trap_take); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %b want 0", bus.flush); end
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", bus.stall); end
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_rv got %b want 0", bus.redirect_valid); end
        checks++; if (bus.redirect_pc !== 32'd0) begin errors++; $display("FAIL rst_pc got %h want 0", bus.redirect_pc); end
        @(negedge clk);
        idle_in();
        rst = 1'b0;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_after_stall got %b want 0", bus.stall); end
    endtask

    task automatic test_exception();
        @(negedge clk);
        bus.exc_valid = 1'b1;
        bus.exc_cause = 4'd2;
        bus.exc_epc   = 32'h0000_0100;
        bus.exc_tval  = 32'h0000_DEAD;
        bus.mret_req  = 1'b1;
        #1;
        checks++; if (bus.trap_take !== 1'b1) begin errors++; $display("FAIL exc_take got %b want 1", bus.trap_take); end
        checks++; if (bus.mret_take !== 1'b0) begin errors++; $display("FAIL exc_mret got %b want 0", bus.mret_take); end
        checks++; if (bus.trap_cause !== 32'h0000_0002) begin errors++; $display("FAIL exc_cause got %h want 00000002", bus.trap_cause); end
        checks++; if (bus.trap_epc !== 32'h0000_0100) begin errors++; $display("FAIL exc_epc got %h want 00000100", bus.trap_epc); end
        checks++; if (bus.trap_tval !== 32'h0000_DEAD) begin errors++; $display("FAIL exc_tval got %h want 0000dead", bus.trap_tval); end
        checks++; if (bus.flush !== 1'b0) begin errors++; $display("FAIL exc_flush_t0 got %b want 0", bus.flush); end
        @(negedge clk);
        idle_in();
        #1;
        checks++; if (bus.trap_take !== 1'b0) begin errors++; $display("FAIL exc_take_t1 got %b want 0", bus.trap_take); end
        checks++; if (bus.flush !== 1'b1 || bus.stall !== 1'b1) begin errors++; $display("FAIL exc_flush_t1 got %b%b want 11", bus.flush, bus.stall); end
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL exc_rv_t1 got %b want 0", bus.redirect_valid); end
        @(negedge clk);
        #1;
        checks++; if (bus.flush !== 1'b1 || bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL exc_flush_t2 got %b%b want 10", bus.flush, bus.redirect_valid); end
        @(negedge clk);
        #1;
        checks++; if (bus.flush !== 1'b0 || bus.stall !== 1'b1) begin errors++; $display("FAIL exc_redir_fs got %b%b want 01", bus.flush, bus.stall); end
        checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL exc_rv_t3 got %b want 1", bus.redirect_valid); end
        checks++; if (bus.redirect_pc !== 32'h8000_0000) begin errors++; $display("FAIL exc_pc got %h want 80000000", bus.redirect_pc); end
        @(negedge clk);
        #1;
        checks++; if (bus.redirect_valid !== 1'b0 || bus.stall !== 1'b0) begin errors++; $display("FAIL exc_idle got %b%b want 00", bus.redirect_valid, bus.stall); end
    endtask

    task automatic test_timer_vectored();
        @(negedge clk);
        bus.mstatus_mie  = 1'b1;
        bus.mie_en       = 3'b001;
        bus.mip_pend     = 3'b001;
        bus.retire_valid = 1'b1;
        bus.retire_npc   = 32'h0000_0204;
        #1;
        checks++; if (bus.trap_take !== 1'b1) begin errors++; $display("FAIL tmr_take got %b want 1", bus.trap_take); end
        checks++; if (bus.trap_cause !== 32'h8000_0007) begin errors++; $display("FAIL tmr_cause got %h want 80000007", bus.trap_cause); end
        checks++; if (bus.trap_epc !== 32'h0000_0204) begin errors++; $display("FAIL tmr_epc got %h want 00000204", bus.trap_epc); end
        checks++; if (bus.trap_tval !== 32'h0) begin errors++; $display("FAIL tmr_tval got %h want 0", bus.trap_tval); end
        @(negedge clk);
        idle_in();
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL tmr_rv got %b want 1", bus.redirect_valid); end
        checks++; if (bus.redirect_pc !== 32'h8000_001C) begin errors++; $display("FAIL tmr_pc got %h want 8000001c", bus.redirect_pc); end
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        bus.mstatus_mie  = 1'b1;
        bus.mie_en       = 3'b111;
        bus.mip_pend     = 3'b111;
        bus.retire_valid = 1'b1;
        bus.retire_npc   = 32'h0000_0400;
        bus.mret_req     = 1'b1;
        #1;
        checks++; if (bus.mret_take !== 1'b1) begin errors++; $display("FAIL sim_mret got %b want 1", bus.mret_take); end
        checks++; if (bus.trap_take !== 1'b0) begin errors++; $display("FAIL sim_take got %b want 0", bus.trap_take); end
        @(negedge clk);
        bus.mret_req = 1'b0;
        #1;
        checks++; if (bus.mret_take !== 1'b0 || bus.trap_take !== 1'b0) begin errors++; $display("FAIL sim_busy_takes got %b%b want 00", bus.mret_take, bus.trap_take); end
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.redirect_pc !== 32'h0000_0300) begin errors++; $display("FAIL sim_mret_pc got %h want 00000300", bus.redirect_pc); end
        // Interrupts still pending: MEI wins once back in IDLE.
        @(negedge clk);
        #1;
        checks++; if (bus.trap_take !== 1'b1) begin errors++; $display("FAIL sim_irq_take got %b want 1", bus.trap_take); end
        checks++; if (bus.trap_cause !== 32'h8000_000B) begin errors++; $display("FAIL sim_irq_cause got %h want 8000000b", bus.trap_cause); end
        checks++; if (bus.trap_epc !== 32'h0000_0400) begin errors++; $display("FAIL sim_irq_epc got %h want 00000400", bus.trap_epc); end
        @(negedge clk);
        idle_in();
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.redirect_pc !== 32'h8000_002C) begin errors++; $display("FAIL sim_irq_pc got %h want 8000002c", bus.redirect_pc); end
        @(negedge clk);
    endtask

    task automatic test_masking();
        bus.mie_en       = 3'b111;
        bus.mip_pend     = 3'b111;
        bus.mstatus_mie  = 1'b0;
        bus.retire_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checks++; if (bus.trap_take !== 1'b0 || bus.flush !== 1'b0) begin errors++; $display("FAIL mask_mie c%0d got %b%b want 00", i, bus.trap_take, bus.flush); end
        end
        bus.mstatus_mie  = 1'b1;
        bus.retire_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            checks++; if (bus.trap_take !== 1'b0 || bus.flush !== 1'b0) begin errors++; $display("FAIL mask_ret c%0d got %b%b want 00", i, bus.trap_take, bus.flush); end
        end
        idle_in();
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        bus.mepc           = 32'h0000_1235;
        bus.mret_req       = 1'b1;
        bus.redirect_ready = 1'b0;
        #1;
        checks++; if (bus.mret_take !== 1'b1) begin errors++; $display("FAIL bp_mret got %b want 1", bus.mret_take); end
        @(negedge clk);
        @(negedge clk);
        // Requests during the hold must be ignored.
        bus.mstatus_mie  = 1'b1;
        bus.mie_en       = 3'b111;
        bus.mip_pend     = 3'b111;
        bus.retire_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++; if (bus.redirect_valid !== 1'b1 || bus.stall !== 1'b1) begin errors++; $display("FAIL bp_hold c%0d got %b%b want 11", i, bus.redirect_valid, bus.stall); end
            checks++; if (bus.redirect_pc !== 32'h0000_1234) begin errors++; $display("FAIL bp_pc c%0d got %h want 00001234", i, bus.redirect_pc); end
            checks++; if (bus.mret_take !== 1'b0 || bus.trap_take !== 1'b0) begin errors++; $display("FAIL bp_ignore c%0d got %b%b want 00", i, bus.mret_take, bus.trap_take); end
        end
        idle_in();
        bus.redirect_ready = 1'b1;
        #1;
        checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL bp_rv_accept got %b want 1", bus.redirect_valid); end
        @(negedge clk);
        #1;
        checks++; if (bus.redirect_valid !== 1'b0 || bus.stall !== 1'b0) begin errors++; $display("FAIL bp_idle got %b%b want 00", bus.redirect_valid, bus.stall); end
    endtask

    task automatic test_reset_mid_flush();
        @(negedge clk);
        bus.exc_valid = 1'b1;
        bus.exc_cause = 4'd4;
        bus.mtvec     = 32'h0000_1000;
        @(negedge clk);
        idle_in();
        bus.mtvec = 32'h0000_1000;
        #1;
        checks++; if (bus.flush !== 1'b1) begin errors++; $display("FAIL rmf_flush got %b want 1", bus.flush); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.flush !== 1'b0 || bus.stall !== 1'b0 || bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL rmf_out got %b%b%b want 000", bus.flush, bus.stall, bus.redirect_valid); end
        checks++; if (bus.redirect_pc !== 32'd0) begin errors++; $display("FAIL rmf_pc got %h want 0", bus.redirect_pc); end
        @(negedge clk);
        #1;
        checks++; if (bus.redirect_valid !== 1'b0 || bus.flush !== 1'b0) begin errors++; $display("FAIL rmf_quiet got %b%b want 00", bus.redirect_valid, bus.flush); end
        // A fresh exception is handled normally.
        bus.exc_valid = 1'b1;
        bus.exc_cause = 4'd7;
        bus.exc_epc   = 32'h0000_0040;
        #1;
        checks++; if (bus.trap_take !== 1'b1 || bus.trap_cause !== 32'h0000_0007) begin errors++; $display("FAIL rmf_exc got %b %h want 1 00000007", bus.trap_take, bus.trap_cause); end
        @(negedge clk);
        idle_in();
        bus.mtvec = 32'h0000_2003;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h0000_1000) begin errors++; $display("FAIL rmf_redir got %b %h want 1 00001000", bus.redirect_valid, bus.redirect_pc); end
        @(negedge clk);
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rmf_idle got %b want 0", bus.stall); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_exception();
        test_timer_vectored();
        test_simultaneous();
        test_masking();
        test_backpressure();
        test_reset_mid_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap sequencer between the pipeline commit stage, the machine CSR file and instruction fetch.
- Arbitrates synchronous exceptions, mret and the three machine interrupt sources; issues a single-cycle commit command to the CSR file.
- Flushes the pipeline for a fixed drain period, then holds a redirect request to fetch until it is accepted.

Parameters:
- FLUSH_CYCLES, 2, cycles flush is held before redirect is offered (legal 1..15)
- VECTORED_EN, 1, honour mtvec[1:0]==1 vectored mode; 0 forces direct mode

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- exc_valid  in  1  synchronous exception at commit
- exc_cause  in  4  exception code
- exc_epc  in  32  pc of faulting instruction
- exc_tval  in  32  trap value
- mret_req  in  1  mret at commit
- retire_valid  in  1  instruction retires this cycle (interrupt boundary)
- retire_npc  in  32  pc of next instruction after the retiring one
- mstatus_mie  in  1  global machine interrupt enable
- mie_en  in  3  {meie,msie,mtie}
- mip_pend  in  3  {meip,msip,mtip}
- mtvec  in  32  trap vector CSR
- mepc  in  32  mepc CSR
- trap_take  out  1  pulse: CSR file writes mepc/mcause/mtval, mpie<=mie, mie<=0
- trap_cause  out  32  mcause value, bit31 = interrupt
- trap_epc  out  32  value for mepc
- trap_tval  out  32  value for mtval (0 for interrupts)
- mret_take  out  1  pulse: CSR file does mie<=mpie, mpie<=0
- flush  out  1  kill all in-flight instructions
- stall  out  1  block commit
- redirect_valid  out  1  new pc offered to fetch
- redirect_pc  out  32  target pc
- redirect_ready  in  1  fetch accepts redirect

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0. A reset mid-sequence aborts to IDLE with no pulse or redirect the next cycle.
- States:
  - IDLE: evaluate requests each cycle.
  - FLUSH: count FLUSH_CYCLES.
  - REDIRECT: hold redirect until handshake.
- Request priority in IDLE (highest first): exc_valid > mret_req > MEI > MSI > MTI.
  - Interrupt x is eligible when mstatus_mie & mie_en[x] & mip_pend[x] & retire_valid.
  - Lower-priority requests in the same cycle are dropped; the pipeline reissues any mret, and interrupts are re-evaluated later.
- Exception taken:
  - trap_take=1 for one cycle (combinational in the accept cycle).
  - trap_cause = {28'b0, exc_cause}; trap_epc = exc_epc; trap_tval = exc_tval.
  - Target = {mtvec[31:2], 2'b00}.
- Interrupt taken:
  - trap_take=1; trap_cause = {1'b1, 27'b0, code}, with code 11 (MEI), 3 (MSI), 7 (MTI).
  - trap_epc = retire_npc; trap_tval = 0.
  - Target = {mtvec[31:2] + code, 2'b00} when VECTORED_EN and mtvec[1:0]==1; otherwise direct. The 30-bit add wraps modulo 2^30.
- mret taken: mret_take=1 for one cycle; target = {mepc[31:1], 1'b0}.
- Target register: on any take, target is registered into redirect_pc and state goes to FLUSH with counter=0.
- FLUSH:
  - flush=1 and stall=1; counter increments each cycle.
  - At counter==FLUSH_CYCLES-1, go to REDIRECT.
- REDIRECT:
  - flush=0, stall=1, redirect_valid=1; redirect_pc stays stable until accepted.
  - On redirect_valid & redirect_ready, return to IDLE next cycle; redirect_valid drops that next cycle.
- While not IDLE: all requests are ignored and no trap_take/mret_take is issued. An exception arriving then is a pipeline bug; an assertion flags exc_valid & ~IDLE.
- Latency: take cycle T; flush on T+1..T+FLUSH_CYCLES; redirect_valid from T+FLUSH_CYCLES+1.
- Output timing: trap_*/mret_take are combinational from IDLE inputs; flush, stall, redirect_valid and redirect_pc are registered state decodes.

Decomposition:
- Shared constants package gains:
  - interrupt codes: mach_extern=11, mach_soft=3, mach_timer=7
  - state enum trap_state_type {IDLE, FLUSH, REDIRECT}
  - trap_ctrl_out_type struct bundling the trap_* outputs, in the same wires package as the other CSR interface structs
- One natural sub-module: irq_prio (combinational priority encoder for eligible interrupts → valid + 4-bit code). All sequencing stays in trap_ctrl.

Test Plan:
- Exception: exc_valid=1, exc_cause=2, exc_epc=0x100, exc_tval=0xDEAD, mtvec=0x8000_0001 → trap_take pulse, trap_cause=0x0000_0002, flush for 2 cycles, redirect_pc=0x8000_0000 (direct despite vectored mode).
- Vectored timer interrupt: mie=1, mie_en=3'b001, mip_pend=3'b001, retire_valid=1, retire_npc=0x204, mtvec=0x8000_0001 → trap_cause=0x8000_0007, trap_epc=0x204, trap_tval=0, redirect_pc=0x8000_001C.
- Simultaneous requests: meip, msip and mtip all pending and enabled, plus mret_req, no exception → mret_take only, redirect_pc=mepc (0x300). Then with all three pending again → cause 0x8000_000B.
- Masking: mstatus_mie=0 with all pending, or retire_valid=0 → no trap_take for 10 cycles, flush stays 0.
- Redirect backpressure: redirect_ready=0 for 5 cycles → redirect_valid held and redirect_pc stable. Requests during the hold are ignored. After ready=1 → IDLE next cycle.
- Reset mid-FLUSH: rst=1 on the first flush cycle → next cycle all outputs 0, no redirect issued; a subsequent exception is handled normally.
